// File: rtl/fetch_sequencer.sv
// Fetch/decode control FSM: fetches opcode and optional operand bytes through
// MAR/MDR into the IR, then hands the instruction to the execute unit.
module fetch_sequencer #(
    parameter logic [7:0]  HALT_OP     = 8'hFF,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mem_ready,
    input  logic [7:0] opcode,
    input  logic       exec_done,
    output logic       load_mar,
    output logic       mem_rd,
    output logic       load_mdr,
    output logic       pc_inc,
    output logic       load_iru,
    output logic       load_irl,
    output logic       exec_start,
    output logic       busy,
    output logic       halted,
    output logic       fault
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_U,
        S_WAIT_U,
        S_LOAD_U,
        S_DECODE,
        S_ADDR_L,
        S_WAIT_L,
        S_LOAD_L,
        S_ISSUE,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_next;
    logic [7:0] wait_cnt;
    logic       in_wait;

    assign in_wait = (state == S_WAIT_U) || (state == S_WAIT_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter is zeroed in the ADDR state so it reads 0 on the first WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if ((state == S_ADDR_U) || (state == S_ADDR_L)) begin
            wait_cnt <= '0;
        end else if (in_wait && !mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        load_mar   = 1'b0;
        mem_rd     = 1'b0;
        load_mdr   = 1'b0;
        pc_inc     = 1'b0;
        load_iru   = 1'b0;
        load_irl   = 1'b0;
        exec_start = 1'b0;
        busy       = 1'b1;
        halted     = 1'b0;
        fault      = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) state_next = S_ADDR_U;
            end
            S_ADDR_U: begin
                load_mar   = 1'b1;
                state_next = S_WAIT_U;
            end
            S_WAIT_U: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    load_mdr   = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = S_LOAD_U;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_FAULT;
                end
            end
            S_LOAD_U: begin
                load_iru   = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == HALT_OP)  state_next = S_HALT;
                else if (opcode[7])     state_next = S_ADDR_L;
                else                    state_next = S_ISSUE;
            end
            S_ADDR_L: begin
                load_mar   = 1'b1;
                state_next = S_WAIT_L;
            end
            S_WAIT_L: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    load_mdr   = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = S_LOAD_L;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_FAULT;
                end
            end
            S_LOAD_L: begin
                load_irl   = 1'b1;
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                exec_start = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) state_next = run ? S_ADDR_U : S_IDLE;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            S_FAULT: begin
                busy  = 1'b0;
                fault = 1'b1;
            end
            default: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
